// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the icache/dcache requesters, the arbiter and the backing memory port.
// The slave modport is the arbiter's view; master is the view of the surrounding caches and memory.
interface riscv_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ic_req_valid;
  logic [ADDR_W-1:0] ic_req_addr;
  logic              ic_req_ready;
  logic              ic_resp_valid;
  logic [DATA_W-1:0] ic_resp_data;
  logic              ic_resp_last;

  logic              dc_req_valid;
  logic              dc_req_rw;
  logic [ADDR_W-1:0] dc_req_addr;
  logic [DATA_W-1:0] dc_req_wdata;
  logic [3:0]        dc_req_wmask;
  logic              dc_req_ready;
  logic              dc_resp_valid;
  logic [DATA_W-1:0] dc_resp_data;
  logic              dc_resp_last;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [3:0]        mem_req_wmask;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  logic              busy;
  logic              protocol_err;

  modport slave (
    input  ic_req_valid, ic_req_addr,
    input  dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
    input  mem_req_ready, mem_resp_valid, mem_resp_data,
    output ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
    output dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
    output busy, protocol_err
  );

  modport master (
    output ic_req_valid, ic_req_addr,
    output dc_req_valid, dc_req_rw, dc_req_addr, dc_req_wdata, dc_req_wmask,
    output mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ic_req_ready, ic_resp_valid, ic_resp_data, ic_resp_last,
    input  dc_req_ready, dc_resp_valid, dc_resp_data, dc_resp_last,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata, mem_req_wmask,
    input  busy, protocol_err
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Shares the single backing-memory port between icache refills and dcache misses/stores.
// One transaction at a time: grant in IDLE, hold the request in REQ, route beats back in RESP.
module riscv_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BEATS  = 4,
  parameter int FAIR   = 0
) (
  input logic clk,
  input logic rst,
  riscv_mem_arbiter_if.slave bus
);

  localparam int LINE_BYTES = BEATS * 4;
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  owner_t            last_owner_q, last_owner_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              busy_q, busy_d;
  logic              perr_q, perr_d;

  logic              grant_dc;
  logic              ic_ready, dc_ready;
  logic              resp_valid, resp_last;
  logic [DATA_W-1:0] resp_data;
  logic              req_active;

  // On a tie the dcache wins unless round-robin says it went last.
  assign grant_dc = bus.dc_req_valid &&
                    (!bus.ic_req_valid || (FAIR == 0) || (last_owner_q == OWN_IC));

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    rw_d         = rw_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    beat_d       = beat_q;
    perr_d       = perr_q;
    ic_ready     = 1'b0;
    dc_ready     = 1'b0;
    req_active   = 1'b0;
    resp_valid   = 1'b0;
    resp_last    = 1'b0;
    resp_data    = '0;

    case (state_q)
      IDLE: begin
        if (bus.mem_resp_valid) perr_d = 1'b1;
        if (grant_dc) begin
          dc_ready     = 1'b1;
          owner_d      = OWN_DC;
          last_owner_d = OWN_DC;
          rw_d         = bus.dc_req_rw;
          addr_d       = bus.dc_req_addr & (bus.dc_req_rw ? WORD_MASK : LINE_MASK);
          wdata_d      = bus.dc_req_rw ? bus.dc_req_wdata : '0;
          wmask_d      = bus.dc_req_rw ? bus.dc_req_wmask : 4'b0000;
          state_d      = REQ;
        end else if (bus.ic_req_valid) begin
          ic_ready     = 1'b1;
          owner_d      = OWN_IC;
          last_owner_d = OWN_IC;
          rw_d         = 1'b0;
          addr_d       = bus.ic_req_addr & LINE_MASK;
          wdata_d      = '0;
          wmask_d      = 4'b0000;
          state_d      = REQ;
        end
      end
      REQ: begin
        req_active = 1'b1;
        if (bus.mem_resp_valid) perr_d = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = RESP;
          beat_d  = '0;
        end
      end
      RESP: begin
        if (bus.mem_resp_valid) begin
          resp_valid = 1'b1;
          if (rw_q) begin
            resp_last = 1'b1;
            state_d   = IDLE;
          end else begin
            resp_data = bus.mem_resp_data;
            resp_last = (beat_q == LAST_BEAT);
            if (beat_q == LAST_BEAT) begin
              state_d = IDLE;
              beat_d  = '0;
            end else begin
              beat_d = beat_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_IC;
      last_owner_q <= OWN_IC;
      rw_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= 4'b0000;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      rw_q         <= rw_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
      perr_q       <= perr_d;
    end
  end

  // Ready is combinational from the request, so hold it low while reset is asserted.
  assign bus.ic_req_ready  = ic_ready && !rst;
  assign bus.dc_req_ready  = dc_ready && !rst;

  assign bus.ic_resp_valid = resp_valid && (owner_q == OWN_IC);
  assign bus.ic_resp_last  = resp_last  && (owner_q == OWN_IC);
  assign bus.ic_resp_data  = (owner_q == OWN_IC) ? resp_data : '0;
  assign bus.dc_resp_valid = resp_valid && (owner_q == OWN_DC);
  assign bus.dc_resp_last  = resp_last  && (owner_q == OWN_DC);
  assign bus.dc_resp_data  = (owner_q == OWN_DC) ? resp_data : '0;

  assign bus.mem_req_valid = req_active;
  assign bus.mem_req_rw    = req_active && rw_q;
  assign bus.mem_req_addr  = req_active ? addr_q : '0;
  assign bus.mem_req_wdata = req_active ? wdata_q : '0;
  assign bus.mem_req_wmask = (req_active && rw_q) ? wmask_q : 4'b0000;

  assign bus.busy          = busy_q;
  assign bus.protocol_err  = perr_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Drives identical stimulus into a fixed-priority and a round-robin arbiter side by side;
// expected response beats are queued per instance when memory beats are driven.
module tb_riscv_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BEATS  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ic_req_valid, dc_req_valid, dc_req_rw;
  logic [31:0] ic_req_addr, dc_req_addr, dc_req_wdata;
  logic [3:0]  dc_req_wmask;
  logic        mem_req_ready, mem_resp_valid;
  logic [31:0] mem_resp_data;

  riscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus0 ();
  riscv_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus1 ();

  assign bus0.ic_req_valid   = ic_req_valid;
  assign bus0.ic_req_addr    = ic_req_addr;
  assign bus0.dc_req_valid   = dc_req_valid;
  assign bus0.dc_req_rw      = dc_req_rw;
  assign bus0.dc_req_addr    = dc_req_addr;
  assign bus0.dc_req_wdata   = dc_req_wdata;
  assign bus0.dc_req_wmask   = dc_req_wmask;
  assign bus0.mem_req_ready  = mem_req_ready;
  assign bus0.mem_resp_valid = mem_resp_valid;
  assign bus0.mem_resp_data  = mem_resp_data;

  assign bus1.ic_req_valid   = ic_req_valid;
  assign bus1.ic_req_addr    = ic_req_addr;
  assign bus1.dc_req_valid   = dc_req_valid;
  assign bus1.dc_req_rw      = dc_req_rw;
  assign bus1.dc_req_addr    = dc_req_addr;
  assign bus1.dc_req_wdata   = dc_req_wdata;
  assign bus1.dc_req_wmask   = dc_req_wmask;
  assign bus1.mem_req_ready  = mem_req_ready;
  assign bus1.mem_resp_valid = mem_resp_valid;
  assign bus1.mem_resp_data  = mem_resp_data;

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .FAIR(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  riscv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .FAIR(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        dc;
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];

  task automatic check_output(input string tag, input logic [67:0] observed, input logic [67:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [67:0] expect_resp(input beat_t b);
    return {!b.dc, !b.dc & b.last, b.dc ? 32'h0 : b.data,
             b.dc,  b.dc & b.last, b.dc ? b.data : 32'h0};
  endfunction

  logic [67:0] obs0, obs1;
  assign obs0 = {bus0.ic_resp_valid, bus0.ic_resp_last, bus0.ic_resp_data,
                 bus0.dc_resp_valid, bus0.dc_resp_last, bus0.dc_resp_data};
  assign obs1 = {bus1.ic_resp_valid, bus1.ic_resp_last, bus1.ic_resp_data,
                 bus1.dc_resp_valid, bus1.dc_resp_last, bus1.dc_resp_data};

  // Any response activity, or any cycle where a beat was expected, consumes one queue entry.
  always @(negedge clk) begin
    if (!rst) begin
      if (q0.size() > 0) check_output("dut0_resp", obs0, expect_resp(q0.pop_front()));
      else if (obs0 != 68'h0) check_output("dut0_unexpected_resp", obs0, 68'h0);
      if (q1.size() > 0) check_output("dut1_resp", obs1, expect_resp(q1.pop_front()));
      else if (obs1 != 68'h0) check_output("dut1_unexpected_resp", obs1, 68'h0);
    end
  end

  task automatic check_reset(input string tag);
    check_output({tag, "_dut0"}, 68'({bus0.busy, bus0.protocol_err, bus0.ic_req_ready, bus0.dc_req_ready,
                                      bus0.ic_resp_valid, bus0.ic_resp_last, bus0.dc_resp_valid, bus0.dc_resp_last,
                                      bus0.mem_req_valid, bus0.mem_req_rw, bus0.mem_req_wmask, bus0.mem_req_addr}), 68'h0);
    check_output({tag, "_dut1"}, 68'({bus1.busy, bus1.protocol_err, bus1.ic_req_ready, bus1.dc_req_ready,
                                      bus1.ic_resp_valid, bus1.ic_resp_last, bus1.dc_resp_valid, bus1.dc_resp_last,
                                      bus1.mem_req_valid, bus1.mem_req_rw, bus1.mem_req_wmask, bus1.mem_req_addr}), 68'h0);
  endtask

  // One full transaction, entered #1 after a rising edge with both arbiters idle.
  // abort_after >= 0 asserts reset before that beat instead of finishing the burst.
  task automatic apply_stimulus(input logic ic_v, input logic dc_v, input logic dc_rw,
                                input logic [31:0] ic_addr, input logic [31:0] dc_addr,
                                input logic [31:0] wdata, input logic [3:0] wmask,
                                input logic own0_dc, input logic own1_dc,
                                input logic [31:0] exp_addr, input logic [31:0] data_base,
                                input int abort_after);
    logic       exp_rw;
    logic [3:0] exp_mask;
    int         nbeats;
    exp_rw   = own0_dc & dc_rw;
    exp_mask = exp_rw ? wmask : 4'b0000;
    nbeats   = exp_rw ? 1 : BEATS;

    ic_req_valid = ic_v;  ic_req_addr  = ic_addr;
    dc_req_valid = dc_v;  dc_req_rw    = dc_rw;   dc_req_addr = dc_addr;
    dc_req_wdata = wdata; dc_req_wmask = wmask;
    @(negedge clk);
    check_output("dut0_grant", 68'({bus0.ic_req_ready, bus0.dc_req_ready}), 68'({!own0_dc, own0_dc}));
    check_output("dut1_grant", 68'({bus1.ic_req_ready, bus1.dc_req_ready}), 68'({!own1_dc, own1_dc}));
    @(posedge clk); #1;

    // Scramble requester fields after the grant; the latched copy must be what reaches memory.
    ic_req_valid = 1'b0; ic_req_addr  = 32'hFFFF_FFFF;
    dc_req_valid = 1'b0; dc_req_rw    = ~dc_rw;   dc_req_addr = 32'hFFFF_FFFF;
    dc_req_wdata = 32'hBAD0_BAD0; dc_req_wmask = ~wmask;

    for (int c = 0; c < 2; c++) begin
      mem_req_ready = (c == 1);
      @(negedge clk);
      check_output("dut0_mem_req", 68'({bus0.busy, bus0.mem_req_valid, bus0.mem_req_rw, bus0.mem_req_addr, bus0.mem_req_wmask}),
                   68'({1'b1, 1'b1, exp_rw, exp_addr, exp_mask}));
      check_output("dut1_mem_req", 68'({bus1.busy, bus1.mem_req_valid, bus1.mem_req_rw, bus1.mem_req_addr, bus1.mem_req_wmask}),
                   68'({1'b1, 1'b1, exp_rw, exp_addr, exp_mask}));
      if (exp_rw) check_output("dut0_mem_wdata", 68'(bus0.mem_req_wdata), 68'(wdata));
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b0;

    for (int i = 0; i < nbeats; i++) begin
      if (i == 2) begin
        mem_resp_valid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == abort_after) begin
        rst = 1'b1;
        #1;
        check_reset("reset_mid_resp");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        return;
      end
      mem_resp_valid = 1'b1;
      mem_resp_data  = exp_rw ? 32'h5555_AAAA : data_base + 32'(i);
      q0.push_back('{dc: own0_dc, data: exp_rw ? 32'h0 : data_base + 32'(i), last: (i == nbeats - 1)});
      q1.push_back('{dc: own1_dc, data: exp_rw ? 32'h0 : data_base + 32'(i), last: (i == nbeats - 1)});
      @(posedge clk); #1;
    end
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;

    @(negedge clk);
    check_output("busy_after_txn", 68'({bus0.busy, bus1.busy}), 68'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    ic_req_valid = 1'b0; ic_req_addr = 32'h0;
    dc_req_valid = 1'b0; dc_req_rw = 1'b0; dc_req_addr = 32'h0;
    dc_req_wdata = 32'h0; dc_req_wmask = 4'h0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = 32'h0;
    #1;
    check_reset("reset_state");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] lone icache read");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000_2014, 32'h0, 32'h0, 4'h0,
                   1'b0, 1'b0, 32'h0000_2010, 32'h0000_00A0, -1);

    $display("[TB] dcache store");
    apply_stimulus(1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_3006, 32'h1122_3344, 4'b1100,
                   1'b1, 1'b1, 32'h0000_3004, 32'h0, -1);

    $display("[TB] stray memory response in IDLE");
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_DEAD;
    @(negedge clk);
    check_output("stray_no_resp", 68'({bus0.ic_resp_valid, bus0.dc_resp_valid, bus1.ic_resp_valid, bus1.dc_resp_valid}), 68'h0);
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    mem_resp_data  = 32'h0;
    @(negedge clk);
    check_output("protocol_err_set", 68'({bus0.protocol_err, bus1.protocol_err}), 68'b11);
    repeat (3) @(posedge clk);
    #1;
    check_output("protocol_err_sticky", 68'({bus0.protocol_err, bus1.protocol_err}), 68'b11);

    $display("[TB] reset during RESP, then fresh icache read");
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000_2014, 32'h0, 32'h0, 4'h0,
                   1'b0, 1'b0, 32'h0000_2010, 32'h0000_00B0, 2);
    apply_stimulus(1'b1, 1'b0, 1'b0, 32'h0000_4038, 32'h0, 32'h0, 4'h0,
                   1'b0, 1'b0, 32'h0000_4030, 32'h0000_00C0, -1);

    $display("[TB] back-to-back ties");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_5004, 32'h0000_5008, 32'h0, 4'h0,
                   1'b1, 1'b1, 32'h0000_5000, 32'h0000_00D0, -1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_5004, 32'h0000_5008, 32'h0, 4'h0,
                   1'b1, 1'b0, 32'h0000_5000, 32'h0000_00E0, -1);
    apply_stimulus(1'b1, 1'b1, 1'b0, 32'h0000_5004, 32'h0000_5008, 32'h0, 4'h0,
                   1'b1, 1'b1, 32'h0000_5000, 32'h0000_00F0, -1);

    @(negedge clk);
    check_output("scoreboard_drained", 68'(q0.size() + q1.size()), 68'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Shares the single backing-memory port between the instruction-cache refill path and the data-cache miss/store path of the 5-stage RISC-V core. Grants one requester at a time, then forwards the request to memory. Routes the response beats back to the granted requester. Exports a busy flag that the pipeline folds into mem_stall.

Parameters:
ADDR_W, 32, address width in bits.
DATA_W, 32, memory beat width in bits; must be 32.
BEATS, 4, beats per read burst (cache line = BEATS*DATA_W bits); power of two, 1..16.
FAIR, 0, 0 = fixed dcache priority, 1 = round-robin between icache and dcache.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ic_req_valid  in  1  icache line-read request
ic_req_addr  in  ADDR_W  icache request byte address
ic_req_ready  out  1  icache request accepted this cycle
ic_resp_valid  out  1  icache read beat valid
ic_resp_data  out  DATA_W  icache read beat data
ic_resp_last  out  1  final beat of icache burst
dc_req_valid  in  1  dcache request
dc_req_rw  in  1  1 = single-word write, 0 = line read
dc_req_addr  in  ADDR_W  dcache request byte address
dc_req_wdata  in  DATA_W  write data
dc_req_wmask  in  4  byte write enables
dc_req_ready  out  1  dcache request accepted this cycle
dc_resp_valid  out  1  dcache read beat or write ack
dc_resp_data  out  DATA_W  dcache read beat data (0 on write ack)
dc_resp_last  out  1  final beat or write ack
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_req_rw  out  1  1 = write
mem_req_addr  out  ADDR_W  memory address
mem_req_wdata  out  DATA_W  memory write data
mem_req_wmask  out  4  memory byte enables
mem_resp_valid  in  1  memory read beat or write ack
mem_resp_data  in  DATA_W  memory read data
busy  out  1  arbiter not in IDLE
protocol_err  out  1  sticky: mem_resp_valid seen outside RESP

Behaviour:
- Reset, asynchronous: state=IDLE; all *_valid, *_ready, *_last, busy, protocol_err = 0; data/addr outputs = 0; beat counter = 0; last_owner = IC.
- States: IDLE, REQ, RESP.
- IDLE: if any request is valid, pick an owner and assert that requester's req_ready combinationally in the same cycle. Latch owner, rw (icache forced 0), addr, wdata, wmask. Go to REQ. The non-owner's req_ready stays 0.
- Arbitration, FAIR=0: dcache wins on a tie.
- Arbitration, FAIR=1: on a tie, the requester that is not last_owner wins. last_owner updates on every grant. A lone requester always wins.
- Address rules: reads drive mem_req_addr with the low log2(BEATS*4) bits cleared (line-aligned). Writes drive it with the low 2 bits cleared.
- REQ: mem_req_valid=1 with latched fields, held stable until mem_req_ready=1. On ready, go to RESP, beat counter = 0.
- Writes: mem_req_wmask = latched mask. Reads: mem_req_wmask = 0.
- RESP, read: each mem_resp_valid forwards mem_resp_data to the owner's resp_data with resp_valid=1 in the same cycle (combinational pass-through). The counter increments per beat. resp_last=1 on beat BEATS-1, then go to IDLE.
- RESP, write: the first mem_resp_valid is the ack. Owner resp_valid=1, resp_last=1, resp_data=0. Go to IDLE.
- Non-owner resp_valid is always 0. Non-owner resp_data = 0.
- Gaps between beats are allowed; the counter holds.
- No new grant in the cycle RESP exits; earliest next grant is the following IDLE cycle. Minimum turnaround: 1 idle cycle between transactions.
- busy = (state != IDLE), registered from state.
- mem_resp_valid in IDLE or REQ is ignored (not forwarded) and sets protocol_err. protocol_err clears only on rst.
- Requester valid dropping after grant has no effect; the latched transaction completes.
- rst asserted mid-transaction: immediate return to IDLE, counter cleared, all outputs to reset values. Outstanding memory beats after reset release set protocol_err.

Test Plan:
- Lone icache read: ic_req_addr=0x0000_2014, BEATS=4, mem_req_ready on 2nd REQ cycle, beats 0xA0..0xA3 -> mem_req_addr=0x0000_2010, rw=0; ic_resp_valid x4 with data 0xA0..0xA3, ic_resp_last only on 0xA3; busy falls next cycle.
- Dcache store: addr=0x0000_3006, wdata=0x1122_3344, wmask=4'b1100 -> mem_req_addr=0x0000_3004, rw=1, wmask=4'b1100; one ack gives dc_resp_valid=dc_resp_last=1, dc_resp_data=0; ic_resp_valid stays 0.
- Simultaneous requests, FAIR=0, three back-to-back ties -> dcache granted all three times; ic_req_ready never high while dc_req_valid is high.
- Simultaneous requests, FAIR=1, ties repeated -> grants alternate DC, IC, DC; first grant after reset goes to DC.
- Stray mem_resp_valid in IDLE with data 0xDEAD -> no resp_valid on either side; protocol_err=1 and stays 1 until rst.
- Reset during RESP after 2 of 4 beats -> outputs return to reset values asynchronously. A fresh icache read afterward completes 4 beats with the counter starting at 0.
